// File: rtl/rs_alu_age_if.sv
// Bundle for the ALU reservation station: dispatch, CDB snoop, flush and result ports.
// The slave modport is the station; the master modport is dispatch, the CDB fabric and the arbiter.
interface rs_alu_age_if #(
    parameter int RS_DEPTH  = 8,
    parameter int ROB_DEPTH = 32,
    parameter int NUM_CDB   = 4,
    parameter int XLEN      = 32
);
    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int OCC_W = $clog2(RS_DEPTH + 1);

    // Handshakes: a transfer happens on a clock edge where valid && ready are both high.
    // valid may not depend on ready; dis_ready and out_valid depend only on registered state.
    logic                     dis_valid;
    logic                     dis_ready;
    logic [3:0]               dis_op;
    logic                     dis_cmp;
    logic [TAG_W-1:0]         dis_rob;
    logic                     dis_rs1_rdy;
    logic [XLEN-1:0]          dis_rs1_val;
    logic [TAG_W-1:0]         dis_rs1_tag;
    logic                     dis_rs2_rdy;
    logic [XLEN-1:0]          dis_rs2_val;
    logic [TAG_W-1:0]         dis_rs2_tag;
    logic [NUM_CDB-1:0]       cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0]  cdb_data;
    logic [TAG_W-1:0]         rob_head;
    logic                     flush_valid;
    logic                     flush_all;
    logic [TAG_W-1:0]         flush_tag;
    logic                     out_valid;
    logic                     out_ready;
    logic [TAG_W-1:0]         out_tag;
    logic [XLEN-1:0]          out_data;
    logic [OCC_W-1:0]         occupancy;

    modport slave (
        input  dis_valid, dis_op, dis_cmp, dis_rob,
        input  dis_rs1_rdy, dis_rs1_val, dis_rs1_tag,
        input  dis_rs2_rdy, dis_rs2_val, dis_rs2_tag,
        input  cdb_valid, cdb_tag, cdb_data, rob_head,
        input  flush_valid, flush_all, flush_tag, out_ready,
        output dis_ready, out_valid, out_tag, out_data, occupancy
    );

    modport master (
        output dis_valid, dis_op, dis_cmp, dis_rob,
        output dis_rs1_rdy, dis_rs1_val, dis_rs1_tag,
        output dis_rs2_rdy, dis_rs2_val, dis_rs2_tag,
        output cdb_valid, cdb_tag, cdb_data, rob_head,
        output flush_valid, flush_all, flush_tag, out_ready,
        input  dis_ready, out_valid, out_tag, out_data, occupancy
    );
endinterface

// File: rtl/rs_alu_age.sv
// ALU reservation station: CDB/self wakeup, oldest-ready issue relative to the ROB head,
// selective squash, and a single registered ALU result stage with valid/ready backpressure.
module rs_alu_age #(
    parameter int RS_DEPTH  = 8,
    parameter int ROB_DEPTH = 32,
    parameter int NUM_CDB   = 4,
    parameter int XLEN      = 32
) (
    input logic         clk,
    input logic         rst,
    rs_alu_age_if.slave bus
);
    localparam int TAG_W = $clog2(ROB_DEPTH);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int OCC_W = $clog2(RS_DEPTH + 1);

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [XLEN-1:0]  data_t;
    typedef logic [IDX_W-1:0] idx_t;

    // Entry state: busy/ready bits carry reset, payload does not need one.
    logic [RS_DEPTH-1:0] busy_q, busy_d;
    logic [RS_DEPTH-1:0] r1_rdy_q, r1_rdy_d;
    logic [RS_DEPTH-1:0] r2_rdy_q, r2_rdy_d;
    logic [RS_DEPTH-1:0] cmp_q, cmp_d;
    logic [3:0]          op_q     [RS_DEPTH];
    logic [3:0]          op_d     [RS_DEPTH];
    tag_t                rob_q    [RS_DEPTH];
    tag_t                rob_d    [RS_DEPTH];
    tag_t                r1_tag_q [RS_DEPTH];
    tag_t                r1_tag_d [RS_DEPTH];
    tag_t                r2_tag_q [RS_DEPTH];
    tag_t                r2_tag_d [RS_DEPTH];
    data_t               r1_val_q [RS_DEPTH];
    data_t               r1_val_d [RS_DEPTH];
    data_t               r2_val_q [RS_DEPTH];
    data_t               r2_val_d [RS_DEPTH];

    logic  out_valid_q, out_valid_d;
    tag_t  out_tag_q, out_tag_d;
    data_t out_data_q, out_data_d;

    // ROB_DEPTH is a power of two, so the TAG_W-bit subtraction is the modular distance.
    function automatic tag_t age_of(input tag_t t, input tag_t head);
        tag_t d;
        d = t - head;
        return d;
    endfunction

    // Returns {hit, data}; later assignments win, so port 0 beats higher ports and the self path.
    function automatic logic [XLEN:0] snoop(
        input tag_t                     t,
        input logic [NUM_CDB-1:0]       cv,
        input logic [NUM_CDB*TAG_W-1:0] ct,
        input logic [NUM_CDB*XLEN-1:0]  cd,
        input logic                     sv,
        input tag_t                     st,
        input data_t                    sd
    );
        logic [XLEN:0] r;
        r = '0;
        if (sv && st == t) r = {1'b1, sd};
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
            if (cv[p] && ct[p*TAG_W +: TAG_W] == t) r = {1'b1, cd[p*XLEN +: XLEN]};
        end
        return r;
    endfunction

    logic                self_bc;
    logic [RS_DEPTH-1:0] elig;
    logic                full;
    logic                dis_fire;
    assign self_bc  = out_valid_q && bus.out_ready;
    assign elig     = busy_q & r1_rdy_q & r2_rdy_q;
    assign full     = &busy_q;
    assign dis_fire = bus.dis_valid && !full && !bus.flush_valid;

    // Squash decisions for every entry and for the output register.
    logic [RS_DEPTH-1:0] sq_vec;
    logic                out_sq;
    always_comb begin
        sq_vec = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            sq_vec[i] = bus.flush_valid && (bus.flush_all ||
                        (age_of(rob_q[i], bus.rob_head) > age_of(bus.flush_tag, bus.rob_head)));
        end
        out_sq = bus.flush_valid && out_valid_q && (bus.flush_all ||
                 (age_of(out_tag_q, bus.rob_head) > age_of(bus.flush_tag, bus.rob_head)));
    end

    // Oldest eligible entry; tags are unique so age ties cannot occur.
    logic sel_found;
    idx_t sel_idx;
    tag_t best_age;
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        best_age  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (elig[i] && (!sel_found || age_of(rob_q[i], bus.rob_head) < best_age)) begin
                sel_found = 1'b1;
                sel_idx   = idx_t'(i);
                best_age  = age_of(rob_q[i], bus.rob_head);
            end
        end
    end

    logic issue_fire;
    assign issue_fire = sel_found && (!out_valid_q || bus.out_ready) && !sq_vec[sel_idx];

    idx_t alloc_idx;
    always_comb begin
        alloc_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!busy_q[i]) alloc_idx = idx_t'(i);
        end
    end

    // ALU on the selected entry.
    data_t      alu_a, alu_b, alu_res;
    logic [2:0] f3;
    logic       alt, br_en;
    logic [4:0] shamt;
    always_comb begin
        alu_a   = r1_val_q[sel_idx];
        alu_b   = r2_val_q[sel_idx];
        f3      = op_q[sel_idx][2:0];
        alt     = op_q[sel_idx][3];
        shamt   = alu_b[4:0];
        br_en   = 1'b0;
        alu_res = '0;
        if (cmp_q[sel_idx]) begin
            case (f3)
                3'b000:  br_en = (alu_a == alu_b);
                3'b001:  br_en = (alu_a != alu_b);
                3'b100:  br_en = ($signed(alu_a) <  $signed(alu_b));
                3'b101:  br_en = ($signed(alu_a) >= $signed(alu_b));
                3'b110:  br_en = (alu_a <  alu_b);
                3'b111:  br_en = (alu_a >= alu_b);
                default: br_en = 1'b0;
            endcase
            alu_res = data_t'(br_en);
        end else begin
            case (f3)
                3'b000:  alu_res = alt ? (alu_a - alu_b) : (alu_a + alu_b);
                3'b001:  alu_res = alu_a << shamt;
                3'b010:  alu_res = data_t'($signed(alu_a) < $signed(alu_b));
                3'b011:  alu_res = data_t'(alu_a < alu_b);
                3'b100:  alu_res = alu_a ^ alu_b;
                3'b101:  alu_res = alt ? data_t'($signed(alu_a) >>> shamt) : (alu_a >> shamt);
                3'b110:  alu_res = alu_a | alu_b;
                default: alu_res = alu_a & alu_b;
            endcase
        end
    end

    logic [XLEN:0] dis_w1, dis_w2, w1, w2;
    always_comb begin
        busy_d   = busy_q;
        r1_rdy_d = r1_rdy_q;
        r2_rdy_d = r2_rdy_q;
        cmp_d    = cmp_q;
        op_d     = op_q;
        rob_d    = rob_q;
        r1_tag_d = r1_tag_q;
        r2_tag_d = r2_tag_q;
        r1_val_d = r1_val_q;
        r2_val_d = r2_val_q;
        w1       = '0;
        w2       = '0;
        dis_w1   = snoop(bus.dis_rs1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data,
                         self_bc, out_tag_q, out_data_q);
        dis_w2   = snoop(bus.dis_rs2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data,
                         self_bc, out_tag_q, out_data_q);
        for (int i = 0; i < RS_DEPTH; i++) begin
            w1 = snoop(r1_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data,
                       self_bc, out_tag_q, out_data_q);
            w2 = snoop(r2_tag_q[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data,
                       self_bc, out_tag_q, out_data_q);
            if (busy_q[i] && !r1_rdy_q[i] && w1[XLEN]) begin
                r1_rdy_d[i] = 1'b1;
                r1_val_d[i] = w1[XLEN-1:0];
            end
            if (busy_q[i] && !r2_rdy_q[i] && w2[XLEN]) begin
                r2_rdy_d[i] = 1'b1;
                r2_val_d[i] = w2[XLEN-1:0];
            end
            if (issue_fire && sel_idx == idx_t'(i)) busy_d[i] = 1'b0;
            if (sq_vec[i]) busy_d[i] = 1'b0;
            // Allocation only targets a free slot, so it never collides with the updates above.
            if (dis_fire && alloc_idx == idx_t'(i)) begin
                busy_d[i]   = 1'b1;
                op_d[i]     = bus.dis_op;
                cmp_d[i]    = bus.dis_cmp;
                rob_d[i]    = bus.dis_rob;
                r1_tag_d[i] = bus.dis_rs1_tag;
                r2_tag_d[i] = bus.dis_rs2_tag;
                r1_rdy_d[i] = bus.dis_rs1_rdy || dis_w1[XLEN];
                r2_rdy_d[i] = bus.dis_rs2_rdy || dis_w2[XLEN];
                r1_val_d[i] = bus.dis_rs1_rdy ? bus.dis_rs1_val : dis_w1[XLEN-1:0];
                r2_val_d[i] = bus.dis_rs2_rdy ? bus.dis_rs2_val : dis_w2[XLEN-1:0];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_data_d  = out_data_q;
        if (self_bc) out_valid_d = 1'b0;
        if (out_sq) begin
            out_valid_d = 1'b0;
            out_tag_d   = '0;
            out_data_d  = '0;
        end
        if (issue_fire) begin
            out_valid_d = 1'b1;
            out_tag_d   = rob_q[sel_idx];
            out_data_d  = alu_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            r1_rdy_q    <= '0;
            r2_rdy_q    <= '0;
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            r1_rdy_q    <= r1_rdy_d;
            r2_rdy_q    <= r2_rdy_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        cmp_q    <= cmp_d;
        op_q     <= op_d;
        rob_q    <= rob_d;
        r1_tag_q <= r1_tag_d;
        r2_tag_q <= r2_tag_d;
        r1_val_q <= r1_val_d;
        r2_val_q <= r2_val_d;
    end

    logic [OCC_W-1:0] occ;
    always_comb begin
        occ = '0;
        for (int i = 0; i < RS_DEPTH; i++) occ = occ + OCC_W'(busy_q[i]);
    end

    assign bus.dis_ready = !full;
    assign bus.out_valid = out_valid_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_data  = out_data_q;
    assign bus.occupancy = occ;
endmodule

// File: tb/tb_rs_alu_age.sv
// Directed bench for rs_alu_age: hand-computed results for latency, wakeup, age order,
// backpressure, flush, full station, ALU/compare ops and mid-operation reset.
module tb_rs_alu_age;
    localparam int RS_DEPTH  = 8;
    localparam int ROB_DEPTH = 32;
    localparam int NUM_CDB   = 4;
    localparam int XLEN      = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rs_alu_age_if #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) bus ();

    rs_alu_age #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(ROB_DEPTH), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the active edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input logic [3:0] op, input logic cmp, input logic [4:0] rob,
                            input logic r1_rdy, input logic [31:0] r1_val, input logic [4:0] r1_tag,
                            input logic r2_rdy, input logic [31:0] r2_val);
        bus.dis_valid   = 1'b1;
        bus.dis_op      = op;
        bus.dis_cmp     = cmp;
        bus.dis_rob     = rob;
        bus.dis_rs1_rdy = r1_rdy;
        bus.dis_rs1_val = r1_val;
        bus.dis_rs1_tag = r1_tag;
        bus.dis_rs2_rdy = r2_rdy;
        bus.dis_rs2_val = r2_val;
        bus.dis_rs2_tag = 5'd0;
        tick();
        bus.dis_valid   = 1'b0;
    endtask

    task automatic bcast(input int p, input logic [4:0] t, input logic [31:0] d);
        bus.cdb_valid[p]         = 1'b1;
        bus.cdb_tag[p*5 +: 5]    = t;
        bus.cdb_data[p*32 +: 32] = d;
    endtask

    task automatic check_out(input string tag, input logic [4:0] t, input logic [31:0] d);
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, "_tag"},   64'(bus.out_tag),   64'(t));
        check({tag, "_data"},  64'(bus.out_data),  64'(d));
    endtask

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;

    // ALU table: {op, cmp, a, b, expected}
    logic [3:0]  t_op  [10] = '{4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b1101,
                                4'b1000, 4'b0100, 4'b0111, 4'b0000, 4'b0001};
    logic        t_cmp [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_a   [10] = '{32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000,
                                32'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd5, 32'd5};
    logic [31:0] t_b   [10] = '{32'd35, 32'd1, 32'd1, 32'd4, 32'd4,
                                32'd1, 32'd2, 32'd2, 32'd6, 32'd6};
    logic [31:0] t_exp [10] = '{32'd8, 32'd1, 32'd0, 32'h0800_0000, 32'hF800_0000,
                                32'hFFFF_FFFF, 32'd1, 32'd1, 32'd0, 32'd1};

    initial begin
        bus.dis_valid   = 1'b0;
        bus.dis_op      = '0;
        bus.dis_cmp     = 1'b0;
        bus.dis_rob     = '0;
        bus.dis_rs1_rdy = 1'b0;
        bus.dis_rs1_val = '0;
        bus.dis_rs1_tag = '0;
        bus.dis_rs2_rdy = 1'b0;
        bus.dis_rs2_val = '0;
        bus.dis_rs2_tag = '0;
        bus.cdb_valid   = '0;
        bus.cdb_tag     = '0;
        bus.cdb_data    = '0;
        bus.rob_head    = '0;
        bus.flush_valid = 1'b0;
        bus.flush_all   = 1'b0;
        bus.flush_tag   = '0;
        bus.out_ready   = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_occ",       64'(bus.occupancy), 64'd0);
        check("rst_dis_ready", 64'(bus.dis_ready), 64'd1);

        // Both ready: 5+7 tag 3, result two edges after the dispatch edge is presented.
        dispatch(OP_ADD, 1'b0, 5'd3, 1'b1, 32'd5, 5'd0, 1'b1, 32'd7);
        check("lat_occ1", 64'(bus.occupancy), 64'd1);
        check("lat_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        check_out("lat", 5'd3, 32'd12);
        check("lat_occ0", 64'(bus.occupancy), 64'd0);
        tick();
        check("lat_drained", 64'(bus.out_valid), 64'd0);

        // CDB wakeup: SUB rs1 on tag 9; ports 2 and 3 both carry tag 9, port 2 wins.
        dispatch(OP_SUB, 1'b0, 5'd10, 1'b0, 32'd0, 5'd9, 1'b1, 32'd1);
        bcast(2, 5'd9, 32'd100);
        bcast(3, 5'd9, 32'd555);
        tick();
        bus.cdb_valid = '0;
        check("wake_no_same_cycle", 64'(bus.out_valid), 64'd0);
        tick();
        check_out("wake", 5'd10, 32'd99);
        tick();

        // Dispatch-time capture of a same-cycle broadcast.
        bcast(0, 5'd12, 32'd40);
        dispatch(OP_ADD, 1'b0, 5'd13, 1'b0, 32'd0, 5'd12, 1'b1, 32'd2);
        bus.cdb_valid = '0;
        tick();
        check_out("dcap", 5'd13, 32'd42);
        tick();

        // Self bypass: tag 14 waits on tag 11 which comes out of this station's own result.
        dispatch(OP_ADD, 1'b0, 5'd11, 1'b1, 32'd1, 5'd0, 1'b1, 32'd2);
        dispatch(OP_ADD, 1'b0, 5'd14, 1'b0, 32'd0, 5'd11, 1'b1, 32'd10);
        check_out("self_src", 5'd11, 32'd3);
        tick();
        check("self_gap", 64'(bus.out_valid), 64'd0);
        tick();
        check_out("self", 5'd14, 32'd13);
        tick();

        // Age order with wraparound: head 30, tag 31 is older than tag 1.
        bus.rob_head = 5'd30;
        dispatch(OP_ADD, 1'b0, 5'd1,  1'b0, 32'd0, 5'd20, 1'b1, 32'd1);
        dispatch(OP_ADD, 1'b0, 5'd31, 1'b0, 32'd0, 5'd20, 1'b1, 32'd2);
        bcast(1, 5'd20, 32'd10);
        tick();
        bus.cdb_valid = '0;
        tick();
        check_out("age_first", 5'd31, 32'd12);
        tick();
        check_out("age_second", 5'd1, 32'd11);
        tick();
        check("age_drained", 64'(bus.out_valid), 64'd0);
        bus.rob_head = 5'd0;

        // Backpressure: output held while out_ready=0, then drains in age order.
        bus.out_ready = 1'b0;
        dispatch(4'b0110, 1'b0, 5'd4, 1'b1, 32'hF0, 5'd0, 1'b1, 32'h0F);
        dispatch(4'b0111, 1'b0, 5'd6, 1'b1, 32'hFF, 5'd0, 1'b1, 32'h3C);
        dispatch(4'b0100, 1'b0, 5'd5, 1'b1, 32'hAA, 5'd0, 1'b1, 32'hFF);
        for (int k = 0; k < 5; k++) begin
            check_out("bp_hold", 5'd4, 32'hFF);
            tick();
        end
        check("bp_occ", 64'(bus.occupancy), 64'd2);
        bus.out_ready = 1'b1;
        tick();
        check_out("bp_rel1", 5'd5, 32'h55);
        tick();
        check_out("bp_rel2", 5'd6, 32'h3C);
        tick();
        check("bp_drained", 64'(bus.out_valid), 64'd0);

        // ALU and compare ops.
        for (int k = 0; k < 10; k++) begin
            dispatch(t_op[k], t_cmp[k], 5'(20 + k), 1'b1, t_a[k], 5'd0, 1'b1, t_b[k]);
            tick();
            check_out($sformatf("alu%0d", k), 5'(20 + k), t_exp[k]);
        end
        tick();

        // Selective flush: head 0, station holds 2,6,7, output holds 8, flush tag 5.
        bus.out_ready = 1'b0;
        dispatch(OP_ADD, 1'b0, 5'd8, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1);
        dispatch(OP_ADD, 1'b0, 5'd2, 1'b0, 32'd0, 5'd20, 1'b1, 32'd3);
        dispatch(OP_ADD, 1'b0, 5'd6, 1'b0, 32'd0, 5'd20, 1'b1, 32'd0);
        dispatch(OP_ADD, 1'b0, 5'd7, 1'b0, 32'd0, 5'd20, 1'b1, 32'd0);
        check("fl_pre_occ", 64'(bus.occupancy), 64'd3);
        check_out("fl_pre_out", 5'd8, 32'd2);
        bus.flush_valid = 1'b1;
        bus.flush_tag   = 5'd5;
        bus.dis_valid   = 1'b1;
        bus.dis_rob     = 5'd3;
        bus.dis_rs1_rdy = 1'b1;
        bus.dis_rs2_rdy = 1'b1;
        tick();
        bus.flush_valid = 1'b0;
        bus.dis_valid   = 1'b0;
        check("fl_occ", 64'(bus.occupancy), 64'd1);
        check("fl_out_cleared", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        check("fl_drop_dis", 64'(bus.out_valid), 64'd0);
        bcast(0, 5'd20, 32'd7);
        tick();
        bus.cdb_valid = '0;
        tick();
        check_out("fl_survivor", 5'd2, 32'd10);
        check("fl_occ0", 64'(bus.occupancy), 64'd0);
        tick();

        // flush_all clears entries a plain flush with tag 31 would keep.
        dispatch(OP_ADD, 1'b0, 5'd3, 1'b0, 32'd0, 5'd20, 1'b1, 32'd0);
        dispatch(OP_ADD, 1'b0, 5'd4, 1'b0, 32'd0, 5'd20, 1'b1, 32'd0);
        bus.flush_valid = 1'b1;
        bus.flush_all   = 1'b1;
        bus.flush_tag   = 5'd31;
        tick();
        bus.flush_valid = 1'b0;
        bus.flush_all   = 1'b0;
        check("flall_occ", 64'(bus.occupancy), 64'd0);

        // Full station: a dispatch offered while full is not taken.
        for (int k = 0; k < RS_DEPTH; k++) begin
            dispatch(OP_ADD, 1'b0, 5'(10 + k), 1'b0, 32'd0, 5'd25, 1'b1, 32'(k));
        end
        check("full_ready", 64'(bus.dis_ready), 64'd0);
        check("full_occ", 64'(bus.occupancy), 64'd8);
        bus.dis_valid   = 1'b1;
        bus.dis_rob     = 5'd30;
        bus.dis_rs1_rdy = 1'b1;
        bus.dis_rs2_rdy = 1'b1;
        tick();
        bus.dis_valid   = 1'b0;
        check("full_no_alloc", 64'(bus.occupancy), 64'd8);
        bcast(3, 5'd25, 32'd100);
        tick();
        bus.cdb_valid = '0;
        check("full_ready_wake", 64'(bus.dis_ready), 64'd0);
        tick();
        check("full_ready_freed", 64'(bus.dis_ready), 64'd1);
        check_out("full_drain0", 5'd10, 32'd100);
        for (int k = 1; k < RS_DEPTH; k++) begin
            tick();
            check_out($sformatf("full_drain%0d", k), 5'(10 + k), 32'(100 + k));
        end
        tick();
        check("full_empty_valid", 64'(bus.out_valid), 64'd0);
        check("full_empty_occ", 64'(bus.occupancy), 64'd0);

        // Reset while holding a result and a waiting entry.
        bus.out_ready = 1'b0;
        dispatch(OP_ADD, 1'b0, 5'd1, 1'b1, 32'd1, 5'd0, 1'b1, 32'd1);
        dispatch(OP_ADD, 1'b0, 5'd2, 1'b1, 32'd2, 5'd0, 1'b1, 32'd2);
        check_out("mrst_pre", 5'd1, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_valid", 64'(bus.out_valid), 64'd0);
        check("mrst_tag",   64'(bus.out_tag),   64'd0);
        check("mrst_data",  64'(bus.out_data),  64'd0);
        check("mrst_occ",   64'(bus.occupancy), 64'd0);
        check("mrst_ready", 64'(bus.dis_ready), 64'd1);
        bus.out_ready = 1'b1;
        tick();
        tick();
        check("mrst_no_ghost", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
